// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C target (slave) and its line front end.
// Holds FSM state encoding, ACK/NACK line levels, field widths and the
// packed line-event payload produced by i2c_line_sync.
package i2c_pkg;

   localparam int unsigned BYTE_W = 8;
   localparam int unsigned ADDR_W = 7;
   localparam int unsigned CNT_W  = 3;

   // Bit counter reload value: MSB index of a byte
   localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(BYTE_W - 1);

   // SDA level seen during the 9th clock
   localparam logic I2C_ACK  = 1'b0;
   localparam logic I2C_NACK = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_ADDR      = 3'd1,
      ST_ADDR_ACK  = 3'd2,
      ST_RX_DATA   = 3'd3,
      ST_RX_ACK    = 3'd4,
      ST_TX_DATA   = 3'd5,
      ST_TX_ACK    = 3'd6,
      ST_WAIT_STOP = 3'd7
   } i2c_state_e;

   // Synchronized SDA level plus single-cycle bus events
   typedef struct packed {
      logic sda;
      logic scl_rise;
      logic scl_fall;
      logic start;
      logic stop;
   } i2c_line_evt_t;

endpackage

// File: rtl/i2c_line_sync.sv
// I2C line front end: synchronizes raw SCL/SDA and decodes SCL edges and
// START/STOP conditions. Shared by the I2C master and target.
// Ports:
//   clk_i, rst_ni  core clock, asynchronous active-low reset
//   scl_i, sda_i   raw bus lines
//   evt_c_o        synchronized SDA and one-cycle events (combinational
//                  from registered state)
module i2c_line_sync
   import i2c_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          scl_i,
   input  logic          sda_i,
   output i2c_line_evt_t evt_c_o
);

   logic [SYNC_STAGES-1:0] scl_sync_q;
   logic [SYNC_STAGES-1:0] sda_sync_q;
   logic                   scl_prev_q;
   logic                   sda_prev_q;
   logic                   scl_s;
   logic                   sda_s;

   assign scl_s = scl_sync_q[SYNC_STAGES-1];
   assign sda_s = sda_sync_q[SYNC_STAGES-1];

   // Synchronizer chains and edge-detect history; reset to idle bus (high)
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         scl_sync_q <= '1;
         sda_sync_q <= '1;
         scl_prev_q <= 1'b1;
         sda_prev_q <= 1'b1;
      end else begin
         scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
         sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
         scl_prev_q <= scl_s;
         sda_prev_q <= sda_s;
      end
   end

   // START/STOP need SCL high on both samples so an SCL edge coinciding
   // with an SDA change is never taken as a bus condition
   always_comb begin
      evt_c_o          = '0;
      evt_c_o.sda      = sda_s;
      evt_c_o.scl_rise = scl_s & ~scl_prev_q;
      evt_c_o.scl_fall = ~scl_s & scl_prev_q;
      evt_c_o.start    = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
      evt_c_o.stop     = scl_s & scl_prev_q & ~sda_prev_q & sda_s;
   end

endmodule

// File: rtl/i2c_slave_fsm.sv
// I2C target controller. Matches a 7-bit address, then receives bytes into
// an RX FIFO or transmits bytes from a first-word-fall-through TX FIFO.
// Lines are driven open-drain through pull-low enables.
// Build option: define I2C_CLK_STRETCH_EN to stretch SCL on RX-full /
// TX-empty instead of NACKing / sending 0xFF.
// Ports:
//   i2c_core_clk_i, reset_ni   core clock (>= 8x SCL), async active-low reset
//   enable_i                   low forces IDLE and releases the bus
//   i2c_scl_i, i2c_sda_i       raw bus lines
//   sda_low_o, scl_low_o       pull-low enables for SDA / SCL
//   rx_data_o, rx_valid_o      received byte and push strobe; rx_full_i
//   tx_data_i, tx_empty_i      TX FIFO head and empty flag; tx_rd_en_o pop
//   rw_o                       R/W bit of current transfer (1 = master reads)
//   busy_o                     high from START until STOP/IDLE
module i2c_slave_fsm
   import i2c_pkg::*;
#(
   parameter logic [ADDR_W-1:0] SLAVE_ADDR  = 7'h50,
   parameter int unsigned       SYNC_STAGES = 2
) (
   input  logic              i2c_core_clk_i,
   input  logic              reset_ni,
   input  logic              enable_i,
   input  logic              i2c_scl_i,
   input  logic              i2c_sda_i,
   output logic              sda_low_o,
   output logic              scl_low_o,
   output logic [BYTE_W-1:0] rx_data_o,
   output logic              rx_valid_o,
   input  logic              rx_full_i,
   input  logic [BYTE_W-1:0] tx_data_i,
   input  logic              tx_empty_i,
   output logic              tx_rd_en_o,
   output logic              rw_o,
   output logic              busy_o
);

`ifdef I2C_CLK_STRETCH_EN
   localparam bit STRETCH_EN = 1'b1;
`else
   localparam bit STRETCH_EN = 1'b0;
`endif

   i2c_line_evt_t line_evt;

   i2c_state_e        state_q,    state_d;
   logic [CNT_W-1:0]  cnt_q,      cnt_d;
   logic [BYTE_W-1:0] shift_q,    shift_d;
   logic              done_q,     done_d;
   logic              stall_q,    stall_d;
   logic              rw_q,       rw_d;
   logic              sda_low_q,  sda_low_d;
   logic              scl_low_q,  scl_low_d;
   logic [BYTE_W-1:0] rx_data_q,  rx_data_d;
   logic              rx_valid_q, rx_valid_d;
   logic              tx_rd_en_q, tx_rd_en_d;
   logic              busy_q,     busy_d;
   logic              load_tx;

   i2c_line_sync #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_line_sync (
      .clk_i   (i2c_core_clk_i),
      .rst_ni  (reset_ni),
      .scl_i   (i2c_scl_i),
      .sda_i   (i2c_sda_i),
      .evt_c_o (line_evt)
   );

   // State and output registers
   always_ff @(posedge i2c_core_clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state_q    <= ST_IDLE;
         cnt_q      <= CNT_RELOAD;
         shift_q    <= '0;
         done_q     <= 1'b0;
         stall_q    <= 1'b0;
         rw_q       <= 1'b0;
         sda_low_q  <= 1'b0;
         scl_low_q  <= 1'b0;
         rx_data_q  <= '0;
         rx_valid_q <= 1'b0;
         tx_rd_en_q <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         shift_q    <= shift_d;
         done_q     <= done_d;
         stall_q    <= stall_d;
         rw_q       <= rw_d;
         sda_low_q  <= sda_low_d;
         scl_low_q  <= scl_low_d;
         rx_data_q  <= rx_data_d;
         rx_valid_q <= rx_valid_d;
         tx_rd_en_q <= tx_rd_en_d;
         busy_q     <= busy_d;
      end
   end

   // Next-state and output logic
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      shift_d    = shift_q;
      done_d     = done_q;
      stall_d    = stall_q;
      rw_d       = rw_q;
      sda_low_d  = sda_low_q;
      scl_low_d  = scl_low_q;
      rx_data_d  = rx_data_q;
      rx_valid_d = 1'b0;
      tx_rd_en_d = 1'b0;
      busy_d     = busy_q;
      load_tx    = 1'b0;

      if (!enable_i) begin
         state_d   = ST_IDLE;
         done_d    = 1'b0;
         stall_d   = 1'b0;
         rw_d      = 1'b0;
         sda_low_d = 1'b0;
         scl_low_d = 1'b0;
         rx_data_d = '0;
         busy_d    = 1'b0;
      end else if (line_evt.stop) begin
         state_d   = ST_IDLE;
         done_d    = 1'b0;
         stall_d   = 1'b0;
         sda_low_d = 1'b0;
         scl_low_d = 1'b0;
         busy_d    = 1'b0;
      end else if (line_evt.start) begin
         state_d   = ST_ADDR;
         cnt_d     = CNT_RELOAD;
         done_d    = 1'b0;
         stall_d   = 1'b0;
         sda_low_d = 1'b0;
         scl_low_d = 1'b0;
         busy_d    = 1'b1;
      end else begin
         case (state_q)
            ST_ADDR: begin
               if (line_evt.scl_rise) begin
                  shift_d = {shift_q[BYTE_W-2:0], line_evt.sda};
                  if (cnt_q == '0) begin
                     done_d = 1'b1;
                     rw_d   = line_evt.sda;
                  end else begin
                     cnt_d = cnt_q - CNT_W'(1);
                  end
               end else if (line_evt.scl_fall && done_q) begin
                  done_d = 1'b0;
                  if (shift_q[BYTE_W-1:1] == SLAVE_ADDR) begin
                     state_d   = ST_ADDR_ACK;
                     sda_low_d = 1'b1;
                  end else begin
                     state_d = ST_WAIT_STOP;
                  end
               end
            end

            // SCL is held by us while stalled, so no fall arrives then
            ST_ADDR_ACK: begin
               if (line_evt.scl_fall || stall_q) begin
                  sda_low_d = 1'b0;
                  if (!rw_q) begin
                     state_d = ST_RX_DATA;
                     cnt_d   = CNT_RELOAD;
                     done_d  = 1'b0;
                  end else begin
                     load_tx = 1'b1;
                  end
               end
            end

            ST_RX_DATA: begin
               if (line_evt.scl_rise) begin
                  shift_d = {shift_q[BYTE_W-2:0], line_evt.sda};
                  if (cnt_q == '0) begin
                     done_d = 1'b1;
                  end else begin
                     cnt_d = cnt_q - CNT_W'(1);
                  end
               end else if ((line_evt.scl_fall && done_q) || stall_q) begin
                  if (!rx_full_i) begin
                     state_d    = ST_RX_ACK;
                     rx_data_d  = shift_q;
                     rx_valid_d = 1'b1;
                     sda_low_d  = 1'b1;
                     done_d     = 1'b0;
                     stall_d    = 1'b0;
                     scl_low_d  = 1'b0;
                  end else if (STRETCH_EN) begin
                     scl_low_d = 1'b1;
                     stall_d   = 1'b1;
                  end else begin
                     state_d = ST_WAIT_STOP;
                     done_d  = 1'b0;
                  end
               end
            end

            ST_RX_ACK: begin
               if (line_evt.scl_fall) begin
                  state_d   = ST_RX_DATA;
                  sda_low_d = 1'b0;
                  cnt_d     = CNT_RELOAD;
                  done_d    = 1'b0;
               end
            end

            // Bit cnt_q is on the line; each fall moves to the next lower bit
            ST_TX_DATA: begin
               if (line_evt.scl_fall) begin
                  if (cnt_q == '0) begin
                     state_d   = ST_TX_ACK;
                     sda_low_d = 1'b0;
                  end else begin
                     cnt_d     = cnt_q - CNT_W'(1);
                     sda_low_d = ~shift_q[cnt_q - CNT_W'(1)];
                  end
               end
            end

            // done_q marks a master ACK seen on the rising edge
            ST_TX_ACK: begin
               if (line_evt.scl_rise) begin
                  if (line_evt.sda == I2C_NACK) begin
                     state_d = ST_WAIT_STOP;
                  end else begin
                     done_d = 1'b1;
                  end
               end else if ((line_evt.scl_fall && done_q) || stall_q) begin
                  done_d  = 1'b0;
                  load_tx = 1'b1;
               end
            end

            ST_IDLE, ST_WAIT_STOP: begin
            end

            default: state_d = ST_IDLE;
         endcase
      end

      // Pop and present the next TX byte, MSB first
      if (load_tx) begin
         if (STRETCH_EN && tx_empty_i) begin
            scl_low_d = 1'b1;
            stall_d   = 1'b1;
         end else begin
            state_d    = ST_TX_DATA;
            cnt_d      = CNT_RELOAD;
            stall_d    = 1'b0;
            scl_low_d  = 1'b0;
            tx_rd_en_d = ~tx_empty_i;
            shift_d    = tx_empty_i ? 8'hFF : tx_data_i;
            sda_low_d  = ~shift_d[BYTE_W-1];
         end
      end
   end

   assign sda_low_o  = sda_low_q;
   assign scl_low_o  = scl_low_q;
   assign rx_data_o  = rx_data_q;
   assign rx_valid_o = rx_valid_q;
   assign tx_rd_en_o = tx_rd_en_q;
   assign rw_o       = rw_q;
   assign busy_o     = busy_q;

endmodule

// File: tb/tb_i2c_slave_fsm.sv
// Self-checking bench for i2c_slave_fsm: a bit-level I2C master drives the
// wired-AND bus; expected ACKs, received bytes and read data come from a
// transaction-level model (address compare, FIFO queue, rx_full per byte).
`timescale 1ns/1ps
module tb_i2c_slave_fsm;
   import i2c_pkg::*;

   localparam logic [6:0] SLV = 7'h50;
   localparam int         Q   = 8;

   logic       clk     = 1'b0;
   logic       rst_n   = 1'b0;
   logic       enable  = 1'b1;
   logic       m_scl   = 1'b1;
   logic       m_sda   = 1'b1;
   logic       rx_full = 1'b0;
   logic       scl_line, sda_line;
   logic       sda_low, scl_low, rx_valid, tx_rd_en, rw, busy, tx_empty;
   logic [7:0] rx_data, tx_data;

   logic [7:0] tx_mem [0:255];
   int         wr_ptr = 0;
   int         rd_ptr = 0;
   int         pop_cnt = 0;
   logic [7:0] rx_log [0:255];
   int         rx_cnt = 0;
   int         busy_falls = 0;
   logic       busy_d1 = 1'b0;

   logic [7:0] wr_data [0:7];
   logic       full_at [0:7];
   logic [7:0] rd_fill [0:7];

   int n_cmp = 0;
   int n_err = 0;

   assign scl_line = m_scl & ~scl_low;
   assign sda_line = m_sda & ~sda_low;
   assign tx_empty = (rd_ptr == wr_ptr);
   assign tx_data  = tx_mem[rd_ptr[7:0]];

   i2c_slave_fsm #(.SLAVE_ADDR(SLV), .SYNC_STAGES(2)) dut (
      .i2c_core_clk_i (clk),
      .reset_ni       (rst_n),
      .enable_i       (enable),
      .i2c_scl_i      (scl_line),
      .i2c_sda_i      (sda_line),
      .sda_low_o      (sda_low),
      .scl_low_o      (scl_low),
      .rx_data_o      (rx_data),
      .rx_valid_o     (rx_valid),
      .rx_full_i      (rx_full),
      .tx_data_i      (tx_data),
      .tx_empty_i     (tx_empty),
      .tx_rd_en_o     (tx_rd_en),
      .rw_o           (rw),
      .busy_o         (busy)
   );

   initial forever #5 clk = ~clk;

   // FIFO side monitors: TX pops, RX pushes, busy falling edges
   always @(posedge clk) begin
      busy_d1 <= busy;
      if (busy_d1 && !busy) busy_falls <= busy_falls + 1;
      if (tx_rd_en) begin
         pop_cnt <= pop_cnt + 1;
         if (rd_ptr != wr_ptr) rd_ptr <= rd_ptr + 1;
      end
      if (rx_valid) begin
         rx_log[rx_cnt[7:0]] <= rx_data;
         rx_cnt <= rx_cnt + 1;
      end
   end

   initial begin
      #800000;
      $display("FAIL watchdog: got no completion, expected $finish");
      $fatal(1, "watchdog");
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic wait_q();
      repeat (Q) @(negedge clk);
   endtask

   task automatic scl_high();
      int guard = 0;
      m_scl = 1'b1;
      while (scl_line !== 1'b1 && guard < 5000) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 5000) check_eq("scl_release", 32'(scl_line), 32'd1);
   endtask

   task automatic clock_bit(input logic b, output logic seen);
      m_sda = b;
      wait_q();
      scl_high();
      wait_q();
      seen = sda_line;
      wait_q();
      m_scl = 1'b0;
      wait_q();
   endtask

   task automatic send_start();
      m_sda = 1'b1;
      wait_q();
      scl_high();
      wait_q();
      m_sda = 1'b0;
      wait_q();
      m_scl = 1'b0;
      wait_q();
   endtask

   task automatic send_stop();
      m_sda = 1'b0;
      wait_q();
      scl_high();
      wait_q();
      m_sda = 1'b1;
      wait_q();
      wait_q();
   endtask

   task automatic write_byte(input logic [7:0] d, output logic ack);
      logic s;
      for (int i = 7; i >= 0; i--) clock_bit(d[i], s);
      clock_bit(1'b1, ack);
   endtask

   task automatic read_byte(input logic mack, output logic [7:0] d);
      logic s;
      for (int i = 7; i >= 0; i--) begin
         clock_bit(1'b1, s);
         d[i] = s;
      end
      clock_bit(mack, s);
   endtask

   // Master write of n bytes from wr_data; full_at[i] holds rx_full for byte i
   task automatic do_write(input logic [6:0] addr, input int n, input logic stop);
      int   base = rx_cnt;
      int   exp_push = 0;
      logic ack;
      logic match = (addr == SLV);
      logic nacked = 1'b0;
      send_start();
      write_byte({addr, 1'b0}, ack);
      check_eq("w_addr_ack", 32'(ack), 32'(match ? I2C_ACK : I2C_NACK));
      check_eq("w_busy", 32'(busy), 32'd1);
      if (match) begin
         check_eq("w_rw", 32'(rw), 32'd0);
         for (int i = 0; i < n && !nacked; i++) begin
            rx_full = full_at[i];
            write_byte(wr_data[i], ack);
            check_eq("w_data_ack", 32'(ack), 32'(full_at[i] ? I2C_NACK : I2C_ACK));
            if (full_at[i]) nacked = 1'b1;
            else exp_push++;
         end
         rx_full = 1'b0;
      end
      if (stop) begin
         send_stop();
         check_eq("w_busy_after_stop", 32'(busy), 32'd0);
      end
      check_eq("w_rx_pushes", 32'(rx_cnt - base), 32'(exp_push));
      for (int i = 0; i < exp_push; i++)
         check_eq("w_rx_byte", 32'(rx_log[8'(base + i)]), 32'(wr_data[i]));
   endtask

   // Master read of n bytes with k bytes (rd_fill) preloaded into the TX FIFO
   task automatic do_read(input logic [6:0] addr, input int n, input int k, input logic stop);
      logic [7:0] model_q [$];
      logic [7:0] d, exp;
      logic       ack;
      logic       match = (addr == SLV);
      int         pbase = pop_cnt;
      wr_ptr = rd_ptr;
      for (int j = 0; j < k; j++) begin
         tx_mem[8'(wr_ptr)] = rd_fill[j];
         wr_ptr = wr_ptr + 1;
         model_q.push_back(rd_fill[j]);
      end
      send_start();
      write_byte({addr, 1'b1}, ack);
      check_eq("r_addr_ack", 32'(ack), 32'(match ? I2C_ACK : I2C_NACK));
      check_eq("r_busy", 32'(busy), 32'd1);
      if (match) begin
         check_eq("r_rw", 32'(rw), 32'd1);
         for (int j = 0; j < n; j++) begin
            read_byte((j == n - 1) ? I2C_NACK : I2C_ACK, d);
            exp = (model_q.size() != 0) ? model_q.pop_front() : 8'hFF;
            check_eq("r_data", 32'(d), 32'(exp));
         end
      end
      check_eq("r_pops", 32'(pop_cnt - pbase), 32'(k - model_q.size()));
      if (stop) begin
         send_stop();
         check_eq("r_busy_after_stop", 32'(busy), 32'd0);
      end
      wr_ptr = rd_ptr;
   endtask

   initial begin
      logic [6:0] a;
      logic       s;
      int         n, k, base, falls0;

      repeat (3) @(negedge clk);
      check_eq("reset_outputs",
               32'({sda_low, scl_low, rx_valid, tx_rd_en, rw, busy, rx_data}), 32'd0);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);

      // Write 0xA5, 0x3C to our address
      wr_data[0] = 8'hA5; wr_data[1] = 8'h3C;
      full_at[0] = 1'b0;  full_at[1] = 1'b0;
      do_write(SLV, 2, 1'b1);

      // Foreign address: no ACK, no push
      do_write(7'h51, 2, 1'b1);

      // Read 0x81, 0x7E; master ACKs then NACKs
      rd_fill[0] = 8'h81; rd_fill[1] = 8'h7E;
      do_read(SLV, 2, 2, 1'b1);

      // Empty TX FIFO substitutes 0xFF without popping
      do_read(SLV, 2, 1, 1'b1);

      // RX FIFO full on the second byte
      wr_data[0] = 8'h5A; wr_data[1] = 8'hC3;
      full_at[0] = 1'b0;  full_at[1] = 1'b1;
      do_write(SLV, 2, 1'b1);

      // Write then repeated START into a read, never passing IDLE
      falls0 = busy_falls;
      wr_data[0] = 8'h11; full_at[0] = 1'b0;
      do_write(SLV, 1, 1'b0);
      rd_fill[0] = 8'h96;
      do_read(SLV, 1, 1, 1'b0);
      check_eq("rstart_no_idle", 32'(busy_falls - falls0), 32'd0);
      send_stop();

      // enable_i drop while ACKing the address
      base = rx_cnt;
      send_start();
      for (int i = 7; i >= 0; i--) begin
         a = SLV;
         clock_bit((i == 0) ? 1'b0 : a[i - 1], s);
      end
      m_sda = 1'b1;
      wait_q();
      scl_high();
      wait_q();
      check_eq("en_ack_driven", 32'(sda_line), 32'd0);
      enable = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check_eq("en_drop_outputs",
               32'({sda_low, scl_low, rx_valid, tx_rd_en, rw, busy}), 32'd0);
      m_scl = 1'b0;
      wait_q();
      send_stop();
      enable = 1'b1;
      wait_q();
      check_eq("en_drop_no_push", 32'(rx_cnt - base), 32'd0);

      // Reset mid-byte while the target drives a 0 data bit
      wr_ptr = rd_ptr;
      tx_mem[8'(wr_ptr)] = 8'h00;
      wr_ptr = wr_ptr + 1;
      send_start();
      write_byte({SLV, 1'b1}, s);
      clock_bit(1'b1, s);
      clock_bit(1'b1, s);
      check_eq("rst_pre_drive", 32'(sda_low), 32'd1);
      rst_n = 1'b0;
      #1;
      check_eq("rst_mid_outputs",
               32'({sda_low, scl_low, rx_valid, tx_rd_en, rw, busy, rx_data}), 32'd0);
      wr_ptr = rd_ptr;
      m_sda = 1'b1;
      wait_q();
      m_scl = 1'b1;
      wait_q();
      rst_n = 1'b1;
      wait_q();
      wr_data[0] = 8'h6D; full_at[0] = 1'b0;
      do_write(SLV, 1, 1'b1);

      // Randomized transactions
      for (int t = 0; t < 20; t++) begin
         a = ($urandom_range(0, 3) != 0) ? SLV : 7'($urandom_range(0, 127));
         n = $urandom_range(1, 4);
         if ($urandom_range(0, 1) == 1) begin
            k = $urandom_range(0, 4);
            for (int j = 0; j < 8; j++) rd_fill[j] = 8'($urandom);
            do_read(a, n, k, 1'b1);
         end else begin
            for (int j = 0; j < 8; j++) begin
               wr_data[j] = 8'($urandom);
               full_at[j] = ($urandom_range(0, 5) == 0);
            end
            do_write(a, n, 1'b1);
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
